uart_rx_ctrl: RTL and testbench
===============================

Name: uart_rx_ctrl

Overview:
- Controller for the 16x-oversampling UART receiver; generates the receiver's `clken` sample tick from a programmable divisor.
- Services the receiver's `rdy`/`rdy_clr` handshake, so each received byte is taken exactly once.
- Buffers bytes in a small show-ahead FIFO with a valid/ready output, and flags overrun when bytes are lost.
- Sits between the receiver and the consuming logic (command parser / register bridge) in the `clk_50m` domain.

Parameters:
- FIFO_DEPTH, 4, byte FIFO entries; power of two, ≥2.
- DIV_W, 16, width of baud divisor.
- TIMEOUT_TICKS, 640, `clken` ticks of inactivity before rx_timeout (4 chars × 10 bits × 16); used only with the optional feature.

Ports:
- clk_50m  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- enable  in  1  1 = baud tick generator runs
- baud_div  in  DIV_W  clk_50m cycles per `clken` tick (0 treated as 1)
- clken  out  1  one-cycle sample enable to receiver
- rcv_rdy  in  1  receiver byte-ready
- rcv_data  in  8  receiver byte
- rcv_rdy_clr  out  1  clear pulse to receiver
- m_data  out  8  FIFO head byte
- m_valid  out  1  FIFO non-empty
- m_ready  in  1  consumer accepts m_data
- level  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy
- overrun  out  1  sticky: a byte was dropped
- overrun_clr  in  1  clears overrun
- rx_timeout  out  1  idle-with-data flag (optional feature)

Behaviour:
- Reset (async, immediate):
  - Outputs: clken=0, rcv_rdy_clr=0, m_valid=0, m_data=0, level=0, overrun=0, rx_timeout=0.
  - Internal state: FIFO pointers and baud counter cleared, FSM=IDLE.
  - Reset mid-byte drops any FIFO contents and any pending receiver byte state in this block.
- Baud generator:
  - Registered counter cnt. When enable=0: cnt held 0, clken=0.
  - When enable=1: if cnt ≥ max(baud_div,1)−1 then cnt←0 and clken←1 for one cycle; else cnt←cnt+1 and clken←0.
  - First tick comes max(baud_div,1) cycles after enable rises. baud_div≤1 gives clken=1 every cycle.
  - A baud_div change takes effect immediately; cnt above the new limit wraps on the next cycle.
- Handshake FSM (IDLE, CLEAR, WAIT):
  - IDLE: on rcv_rdy=1, push rcv_data into FIFO at that edge, then go to CLEAR. If FIFO full and no pop this cycle: drop the byte, set overrun, still go to CLEAR.
  - CLEAR: rcv_rdy_clr=1 for exactly this one cycle, then go to WAIT.
  - WAIT: stay until rcv_rdy=0, then go to IDLE. This guarantees no double-capture if the receiver's set and clear coincide.
  - rcv_rdy_clr is a registered output, high only in CLEAR.
  - Latency: rcv_rdy sampled high in cycle N → m_valid=1 and rcv_rdy_clr=1 in cycle N+1. Minimum 3 cycles per byte.
  - FSM runs regardless of enable.
- FIFO (show-ahead):
  - m_data is the head entry, valid while m_valid=1. Pop on m_valid & m_ready.
  - Push and pop in the same cycle: both happen and level is unchanged. When full, this counts as space available, so no overrun.
  - Pop when empty is ignored. Pointers wrap modulo FIFO_DEPTH. level = push count − pop count, range 0..FIFO_DEPTH.
- overrun:
  - Set on drop; cleared by overrun_clr.
  - Drop and overrun_clr in the same cycle: set wins.
- The default state encoding decodes to IDLE.

Optional Feature:
- Macro: UART_RX_TIMEOUT_EN.
- With the macro:
  - A counter increments on each clken while m_valid=1.
  - The counter clears on any push or when the FIFO is empty.
  - rx_timeout=1 while counter ≥ TIMEOUT_TICKS; the counter saturates there.
- Without the macro: the counter is not built and rx_timeout is tied to 0.

Decomposition:
- Package uart_pkg holds:
  - the FSM state encoding (IDLE=2'b00, CLEAR=2'b01, WAIT=2'b10);
  - the constant UART_OVERSAMPLE=16;
  - the helper constant DEFAULT_BAUD_DIV=27 (50 MHz / (115200 × 16)).
- One sub-module is natural: uart_rx_fifo (parameterised show-ahead byte FIFO with level, full and empty outputs). Baud generator and FSM stay in the top.

Test Plan:
- baud_div=27, enable=1 → clken pulses exactly every 27 cycles; baud_div=0 → clken high every cycle; enable=0 → clken=0 and cnt=0.
- Receiver model asserts rcv_rdy with rcv_data=8'hA5 at cycle N → FIFO push at N; m_valid=1, m_data=8'hA5, rcv_rdy_clr=1 at N+1 only; level=1; exactly one entry despite rdy being held until the clear.
- m_ready=0, push 5 bytes 8'h01..8'h05 → level=4, overrun=1, then pops return 01,02,03,04. overrun_clr → 0, but set wins if a drop coincides with the clear.
- FIFO full with m_ready=1 while a new byte (8'h3C) arrives → pop and push in the same cycle, no overrun, level stays 4, 8'h3C emerges last.
- Assert rst mid-sequence (state CLEAR, level=2) → all outputs 0 asynchronously, level=0, FSM IDLE after release.
- With UART_RX_TIMEOUT_EN and baud_div=1: one byte held unread → rx_timeout=1 after 640 clken ticks; a pop that empties the FIFO, or a new push, clears it.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared state encoding and constants for the UART receive controller
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        CLEAR = 2'b01,
        WAIT  = 2'b10
    } rx_state_t;

    localparam int UART_OVERSAMPLE  = 16;
    // 50 MHz / (115200 * 16), rounded
    localparam int DEFAULT_BAUD_DIV = 27;

endpackage

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - show-ahead byte FIFO with occupancy level; head byte reads 0 when empty
module uart_rx_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     clk_50m,
    input  logic                     rst,
    input  logic                     push,
    input  logic [7:0]               wdata,
    input  logic                     pop,
    output logic [7:0]               rdata,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (level == '0);
    assign full    = (level == LW'(DEPTH));
    assign do_pop  = pop && !empty;
    // a simultaneous pop frees the slot, so a full FIFO still accepts the push
    assign do_push = push && (!full || do_pop);
    assign rdata   = empty ? 8'h00 : mem[rd_ptr];

    always_ff @(posedge clk_50m or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk_50m) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// rtl/uart_rx_ctrl.sv - UART receiver controller: baud tick, rdy/rdy_clr handshake, byte FIFO, overrun
// Optional idle-with-data timeout is built only when UART_RX_TIMEOUT_EN is defined.
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH    = 4,
    parameter int DIV_W         = 16,
    parameter int TIMEOUT_TICKS = 4 * 10 * UART_OVERSAMPLE
) (
    input  logic                          clk_50m,
    input  logic                          rst,
    input  logic                          enable,
    input  logic [DIV_W-1:0]              baud_div,
    output logic                          clken,
    input  logic                          rcv_rdy,
    input  logic [7:0]                    rcv_data,
    output logic                          rcv_rdy_clr,
    output logic [7:0]                    m_data,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          overrun,
    input  logic                          overrun_clr,
    output logic                          rx_timeout
);

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TIMEOUT_TICKS < 1) begin : g_param_check
        $error("uart_rx_ctrl: FIFO_DEPTH must be a power of two >= 2 and TIMEOUT_TICKS >= 1");
    end

    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] div_lim;
    rx_state_t        state_q;
    rx_state_t        state_d;
    logic             take;
    logic             drop;
    logic             fifo_full;
    logic             fifo_empty;

    assign div_lim = (baud_div == '0) ? DIV_W'(1) : baud_div;

    always_ff @(posedge clk_50m or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            clken <= 1'b0;
        end else if (!enable) begin
            cnt   <= '0;
            clken <= 1'b0;
        end else if (cnt >= div_lim - DIV_W'(1)) begin
            cnt   <= '0;
            clken <= 1'b1;
        end else begin
            cnt   <= cnt + DIV_W'(1);
            clken <= 1'b0;
        end
    end

    // WAIT holds until rdy drops so a byte is never captured twice
    always_comb begin
        state_d = state_q;
        take    = 1'b0;
        case (state_q)
            CLEAR: state_d = WAIT;
            WAIT:  if (!rcv_rdy) state_d = IDLE;
            default: begin
                if (rcv_rdy) begin
                    take    = 1'b1;
                    state_d = CLEAR;
                end else begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk_50m or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    assign rcv_rdy_clr = (state_q == CLEAR);
    assign drop        = take && fifo_full && !m_ready;
    assign m_valid     = !fifo_empty;

    uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_50m (clk_50m),
        .rst     (rst),
        .push    (take),
        .wdata   (rcv_data),
        .pop     (m_ready),
        .rdata   (m_data),
        .level   (level),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_ff @(posedge clk_50m or posedge rst) begin
        if (rst)              overrun <= 1'b0;
        else if (drop)        overrun <= 1'b1;
        else if (overrun_clr) overrun <= 1'b0;
    end

`ifdef UART_RX_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_TICKS + 1);

    logic [TW-1:0] idle_ticks;
    logic          push_ok;

    assign push_ok = take && !drop;

    always_ff @(posedge clk_50m or posedge rst) begin
        if (rst)
            idle_ticks <= '0;
        else if (push_ok || fifo_empty)
            idle_ticks <= '0;
        else if (clken && idle_ticks < TW'(TIMEOUT_TICKS))
            idle_ticks <= idle_ticks + TW'(1);
    end

    assign rx_timeout = !fifo_empty && (idle_ticks >= TW'(TIMEOUT_TICKS));
`else
    assign rx_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb/tb_uart_rx_ctrl.sv - self-checking bench for uart_rx_ctrl with a queue-based reference model
module tb_uart_rx_ctrl;

    localparam int DEPTH = 4;
    localparam int DW    = 16;
    localparam int TT    = 640;
`ifdef UART_RX_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic          clk_50m;
    logic          rst;
    logic          enable;
    logic [DW-1:0] baud_div;
    logic          clken;
    logic          rcv_rdy;
    logic [7:0]    rcv_data;
    logic          rcv_rdy_clr;
    logic [7:0]    m_data;
    logic          m_valid;
    logic          m_ready;
    logic [2:0]    level;
    logic          overrun;
    logic          overrun_clr;
    logic          rx_timeout;

    int checks = 0;
    int errors = 0;
    bit rand_on = 0;

    uart_rx_ctrl #(
        .FIFO_DEPTH    (DEPTH),
        .DIV_W         (DW),
        .TIMEOUT_TICKS (TT)
    ) dut (
        .clk_50m     (clk_50m),
        .rst         (rst),
        .enable      (enable),
        .baud_div    (baud_div),
        .clken       (clken),
        .rcv_rdy     (rcv_rdy),
        .rcv_data    (rcv_data),
        .rcv_rdy_clr (rcv_rdy_clr),
        .m_data      (m_data),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .level       (level),
        .overrun     (overrun),
        .overrun_clr (overrun_clr),
        .rx_timeout  (rx_timeout)
    );

    initial clk_50m = 1'b0;
    always #5 clk_50m = ~clk_50m;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: byte queue, handshake phase flags, baud phase, idle tick count
    logic [7:0] q[$];
    bit m_clr, m_wait, m_ovr, m_clken;
    int m_phase, m_idle;

    always @(posedge clk_50m or posedge rst) begin
        if (rst) begin
            q.delete();
            m_clr = 0; m_wait = 0; m_ovr = 0; m_clken = 0;
            m_phase = 0; m_idle = 0;
        end else begin : model_step
            int lim;
            bit pop, accept, pushed, dropped, was_empty, tick_now;
            lim       = (baud_div == 0) ? 1 : int'(baud_div);
            pop       = (q.size() > 0) && m_ready;
            accept    = !m_clr && !m_wait && rcv_rdy;
            pushed    = 0;
            dropped   = 0;
            was_empty = (q.size() == 0);
            tick_now  = m_clken;
            if (accept) begin
                if (q.size() < DEPTH || pop) pushed = 1;
                else dropped = 1;
            end
            if (pop) void'(q.pop_front());
            if (pushed) q.push_back(rcv_data);
            if (dropped) m_ovr = 1;
            else if (overrun_clr) m_ovr = 0;
            m_wait = m_clr ? 1'b1 : (m_wait && rcv_rdy);
            m_clr  = accept;
            if (!enable) begin
                m_phase = 0; m_clken = 0;
            end else begin
                m_phase++;
                if (m_phase >= lim) begin m_phase = 0; m_clken = 1; end
                else m_clken = 0;
            end
            if (pushed || was_empty) m_idle = 0;
            else if (tick_now && m_idle < TT) m_idle++;
        end
    end

    always @(negedge clk_50m) begin
        chk("clken", clken, m_clken);
        chk("rcv_rdy_clr", rcv_rdy_clr, m_clr);
        chk("m_valid", m_valid, q.size() > 0);
        chk("m_data", m_data, (q.size() > 0) ? q[0] : 8'h00);
        chk("level", level, q.size());
        chk("overrun", overrun, m_ovr);
        chk("rx_timeout", rx_timeout, TO_EN && (m_idle >= TT) && (q.size() > 0));
    end

    always @(posedge clk_50m) begin
        if (rand_on) begin
            #1;
            m_ready     = ($urandom_range(0, 1) == 1);
            overrun_clr = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 63) == 0) enable = ~enable;
            if ($urandom_range(0, 99) == 0) baud_div = DW'($urandom_range(0, 5));
        end
    end

    task automatic step();
        @(posedge clk_50m);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int extra_hold);
        bit got;
        got = 0;
        rcv_rdy  = 1'b1;
        rcv_data = b;
        for (int i = 0; i < 20 && !got; i++) begin
            step();
            if (rcv_rdy_clr) got = 1;
        end
        if (!got) chk("rdy_clr_wait_bound", 0, 1);
        repeat (extra_hold) step();
        rcv_rdy  = 1'b0;
        rcv_data = 8'($urandom);
        repeat (2) step();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int first, second;
        logic [7:0] exp_bytes[4];
        rst = 1; enable = 0; baud_div = 0; rcv_rdy = 0; rcv_data = 0;
        m_ready = 0; overrun_clr = 0;
        repeat (3) step();
        chk("rst_clken", clken, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_level", level, 0);
        chk("rst_m_data", m_data, 0);
        rst = 0;
        step();

        baud_div = 27; enable = 1;
        first = -1; second = -1;
        for (int k = 1; k <= 60; k++) begin
            step();
            if (clken) begin
                if (first < 0) first = k;
                else if (second < 0) second = k;
            end
        end
        chk("first_tick_27", first, 27);
        chk("tick_period_27", second - first, 27);
        baud_div = 0;
        for (int k = 0; k < 5; k++) begin step(); chk("div0_every_cycle", clken, 1); end
        enable = 0;
        for (int k = 0; k < 3; k++) begin step(); chk("disabled_clken", clken, 0); end
        baud_div = 3; enable = 1;
        step(); chk("div3_k1", clken, 0);
        step(); chk("div3_k2", clken, 0);
        step(); chk("div3_k3", clken, 1);
        enable = 0;

        rcv_rdy = 1; rcv_data = 8'hA5;
        step();
        chk("a5_m_valid", m_valid, 1);
        chk("a5_m_data", m_data, 8'hA5);
        chk("a5_clr", rcv_rdy_clr, 1);
        chk("a5_level", level, 1);
        step();
        chk("a5_clr_once", rcv_rdy_clr, 0);
        chk("a5_single_entry", level, 1);
        rcv_rdy = 0;
        repeat (2) step();
        chk("a5_still_single", level, 1);
        m_ready = 1; step(); m_ready = 0;
        chk("a5_drained", level, 0);

        for (int b = 1; b <= 5; b++) send_byte(8'(b), 0);
        chk("ovr_level_full", level, 4);
        chk("ovr_set", overrun, 1);
        m_ready = 1;
        for (int b = 1; b <= 4; b++) begin chk("ovr_pop_order", m_data, 8'(b)); step(); end
        m_ready = 0;
        chk("ovr_drained", level, 0);
        overrun_clr = 1; step(); overrun_clr = 0;
        chk("ovr_cleared", overrun, 0);

        send_byte(8'h11, 0); send_byte(8'h22, 1); send_byte(8'h33, 0); send_byte(8'h44, 2);
        rcv_rdy = 1; rcv_data = 8'h55; overrun_clr = 1;
        step();
        chk("ovr_set_wins", overrun, 1);
        overrun_clr = 0; rcv_rdy = 0;
        repeat (2) step();
        overrun_clr = 1; step(); overrun_clr = 0;
        chk("ovr_cleared2", overrun, 0);

        chk("full_before", level, 4);
        m_ready = 1; rcv_rdy = 1; rcv_data = 8'h3C;
        step();
        chk("full_pushpop_level", level, 4);
        chk("full_pushpop_ovr", overrun, 0);
        m_ready = 0; rcv_rdy = 0;
        repeat (2) step();
        exp_bytes[0] = 8'h22; exp_bytes[1] = 8'h33; exp_bytes[2] = 8'h44; exp_bytes[3] = 8'h3C;
        m_ready = 1;
        for (int i = 0; i < 4; i++) begin chk("full_pushpop_order", m_data, exp_bytes[i]); step(); end
        m_ready = 0;
        chk("full_drained", level, 0);

        enable = 1; baud_div = 2;
        send_byte(8'h61, 0);
        rcv_rdy = 1; rcv_data = 8'h62;
        step();
        chk("pre_rst_clr", rcv_rdy_clr, 1);
        chk("pre_rst_level", level, 2);
        #2; rst = 1; #1;
        chk("async_rst_clken", clken, 0);
        chk("async_rst_clr", rcv_rdy_clr, 0);
        chk("async_rst_m_valid", m_valid, 0);
        chk("async_rst_m_data", m_data, 0);
        chk("async_rst_level", level, 0);
        chk("async_rst_overrun", overrun, 0);
        chk("async_rst_timeout", rx_timeout, 0);
        rcv_rdy = 0;
        repeat (2) step();
        rst = 0;
        rcv_rdy = 1; rcv_data = 8'h77;
        step();
        chk("idle_after_rst_clr", rcv_rdy_clr, 1);
        chk("idle_after_rst_level", level, 1);
        rcv_rdy = 0;
        repeat (2) step();
        m_ready = 1; step(); m_ready = 0;

        rand_on = 1;
        for (int n = 0; n < 150; n++) begin
            repeat ($urandom_range(0, 6)) step();
            send_byte(8'($urandom), int'($urandom_range(0, 2)));
        end
        rand_on = 0;
        step();
        m_ready = 1; overrun_clr = 1;
        repeat (6) step();
        m_ready = 0; overrun_clr = 0;
        chk("random_drained", level, 0);

        baud_div = 1; enable = 1;
        send_byte(8'h5A, 0);
        repeat (600) step();
        chk("timeout_early", rx_timeout, 0);
        repeat (60) step();
        chk("timeout_set", rx_timeout, TO_EN);
        send_byte(8'h6B, 0);
        chk("timeout_push_clears", rx_timeout, 0);
        repeat (700) step();
        chk("timeout_set2", rx_timeout, TO_EN);
        m_ready = 1;
        repeat (2) step();
        m_ready = 0;
        chk("timeout_pop_clears", rx_timeout, 0);
        chk("timeout_empty", m_valid, 0);
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
